if_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. Owns the program counter and produces PC+4 for the next-PC mux, then registers the mux's selected next PC as the new PC. Issues one instruction-memory request per PC using a req/ready handshake and loads the IF/ID pipeline register. Honours hazard-unit stalls and branch/jump flushes, including a redirect that arrives while a memory request is still outstanding.

---
 rtl/if_stage.sv | 159 +++++++++++++++
 tb/tb_if_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, imem req/ready handshake and IF/ID register.
// Optional performance counters are enabled with `define IF_PERF_COUNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  output logic [31:0] pc4,
  output logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [31:0] fetch_count,
  output logic [31:0] wait_count
);

  typedef enum logic [1:0] {StFetch, StDrain, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        deliver;

  assign pc4       = pc_q + 32'd4;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  // Request drops combinationally during reset so an outstanding read is abandoned at once.
  assign imem_req  = rst_n & (state_q != StHold);

  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    deliver      = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (imem_ready) begin
          if (flush) begin
            ifid_valid_d = 1'b0;
            pc_d         = npc;
          end else if (stall) begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = pc4;
            state_d      = StHold;
          end else begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc4;
            pc_d         = npc;
            deliver      = 1'b1;
          end
        end else if (flush) begin
          // Read still in flight: remember the target and let the old access finish.
          redirect_d   = npc;
          ifid_valid_d = 1'b0;
          state_d      = StDrain;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
      end
      StDrain: begin
        ifid_valid_d = 1'b0;
        if (imem_ready) begin
          pc_d    = flush ? npc : redirect_q;
          state_d = StFetch;
        end else if (flush) begin
          redirect_d = npc;
        end
      end
      StHold: begin
        if (flush) begin
          ifid_valid_d = 1'b0;
          pc_d         = npc;
          state_d      = StFetch;
        end else if (!stall) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = hold_instr_q;
          ifid_pc4_d   = hold_pc4_q;
          pc_d         = npc;
          state_d      = StFetch;
          deliver      = 1'b1;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      redirect_q   <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

`ifdef IF_PERF_COUNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'h0, deliver};
    wait_cnt_d  = wait_cnt_q + {31'h0, (state_q != StHold) && !imem_ready};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      wait_cnt_q  <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign wait_count  = wait_cnt_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
  assign fetch_count    = 32'h0;
  assign wait_count     = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; memory returns addr ^ 32'hDEAD_0000.
module tb_if_stage;

`ifdef IF_PERF_COUNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc;
  logic [31:0] pc4;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [31:0] fetch_count;
  logic [31:0] wait_count;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc        (npc),
    .pc4        (pc4),
    .pc         (pc),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .fetch_count(fetch_count),
    .wait_count (wait_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] p4);
    chk({tag, "_valid"}, {31'h0, ifid_valid}, {31'h0, v});
    chk({tag, "_instr"}, ifid_instr, instr);
    chk({tag, "_pc4"}, ifid_pc4, p4);
  endtask

  task automatic chk_cnt(input string tag, input int f, input int w);
    chk({tag, "_fetch_cnt"}, fetch_count, PerfEn ? 32'(f) : 32'h0);
    chk({tag, "_wait_cnt"}, wait_count, PerfEn ? 32'(w) : 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b1; npc = 32'h0;
    #1;
    chk("req_in_reset", {31'h0, imem_req}, 32'h0);
    step();
    chk("rst_pc", pc, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, 32'h0);
    chk_cnt("rst", 0, 0);

    // Sequential fetch from 0
    rst_n = 1'b1; npc = 32'h4; #1;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("addr0", imem_addr, 32'h0);
    chk("pc4_0", pc4, 32'h4);
    step();
    chk_ifid("seq0", 1'b1, 32'hDEAD_0000, 32'h4);
    chk("addr4", imem_addr, 32'h4);

    // Stall on return at pc 4
    stall = 1'b1; npc = 32'h8;
    step();
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_pc", pc, 32'h4);
    chk_ifid("hold1", 1'b1, 32'hDEAD_0000, 32'h4);
    step();
    chk("hold2_req", {31'h0, imem_req}, 32'h0);
    chk_ifid("hold2", 1'b1, 32'hDEAD_0000, 32'h4);
    stall = 1'b0;
    step();
    chk_ifid("release", 1'b1, 32'hDEAD_0004, 32'h8);
    chk("release_pc", pc, 32'h8);
    chk_cnt("release", 2, 0);

    // Three wait states at pc 8; npc must be ignored
    imem_ready = 1'b0; npc = 32'h0000_0BAD;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_valid", {31'h0, ifid_valid}, 32'h0);
    end
    chk_cnt("waits", 2, 3);
    imem_ready = 1'b1; npc = 32'hC;
    step();
    chk_ifid("after_wait", 1'b1, 32'hDEAD_0008, 32'hC);
    npc = 32'h10;
    step();
    chk_ifid("seq12", 1'b1, 32'hDEAD_000C, 32'h10);
    chk("pc16", pc, 32'h10);

    // Flush while waiting at pc 16, then a second flush in DRAIN
    imem_ready = 1'b0; flush = 1'b1; npc = 32'h100;
    step();
    chk("drain_addr", imem_addr, 32'h10);
    chk("drain_req", {31'h0, imem_req}, 32'h1);
    chk("drain_valid", {31'h0, ifid_valid}, 32'h0);
    flush = 1'b0; npc = 32'h999;
    step();
    chk("drain_addr2", imem_addr, 32'h10);
    flush = 1'b1; npc = 32'h200;
    step();
    chk("drain_addr3", imem_addr, 32'h10);
    flush = 1'b0; imem_ready = 1'b1; npc = 32'h300;
    step();
    chk("redirect_addr", imem_addr, 32'h200);
    chk("redirect_valid", {31'h0, ifid_valid}, 32'h0);
    chk_cnt("drain", 4, 6);

    // Flush beats stall in HOLD
    stall = 1'b1; npc = 32'h204;
    step();
    chk("hold_b_req", {31'h0, imem_req}, 32'h0);
    flush = 1'b1; npc = 32'h400;
    step();
    chk("flush_hold_pc", pc, 32'h400);
    chk("flush_hold_valid", {31'h0, ifid_valid}, 32'h0);
    chk("flush_hold_req", {31'h0, imem_req}, 32'h1);
    stall = 1'b0; flush = 1'b0; npc = 32'h404;
    step();
    chk_ifid("after_hold_flush", 1'b1, 32'hDEAD_0400, 32'h404);

    // Flush with ready: target on imem_addr next cycle, data discarded
    flush = 1'b1; npc = 32'h500;
    step();
    chk("flush_rdy_addr", imem_addr, 32'h500);
    chk("flush_rdy_valid", {31'h0, ifid_valid}, 32'h0);

    // pc4 wraparound
    npc = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc4", pc4, 32'h0);
    flush = 1'b0; npc = 32'h0;
    step();
    chk_ifid("wrap", 1'b1, 32'h2152_FFFC, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk_cnt("wrap", 6, 6);

    // Stall with no ready in FETCH: everything holds
    stall = 1'b1; imem_ready = 1'b0; npc = 32'h777;
    step();
    chk_ifid("stall_wait", 1'b1, 32'h2152_FFFC, 32'h0);
    chk("stall_wait_pc", pc, 32'h0);

    // Mid-run reset during DRAIN
    stall = 1'b0; flush = 1'b1; npc = 32'h600;
    step();
    chk("pre_rst_addr", imem_addr, 32'h0);
    chk_cnt("pre_rst", 6, 8);
    flush = 1'b0; rst_n = 1'b0; #1;
    chk("rst_mid_req", {31'h0, imem_req}, 32'h0);
    step();
    chk("rst_mid_pc", pc, 32'h0);
    chk("rst_mid_req2", {31'h0, imem_req}, 32'h0);
    chk_ifid("rst_mid", 1'b0, 32'h0, 32'h0);
    chk_cnt("rst_mid", 0, 0);
    rst_n = 1'b1; imem_ready = 1'b1; npc = 32'h4; #1;
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    step();
    chk_ifid("post_rst", 1'b1, 32'hDEAD_0000, 32'h4);
    chk_cnt("post_rst", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
